// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock health monitor.
// The range check is widened to int so that EXP_PERIOD-TOL can never wrap.
package clk_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        MEAS,
        LOCKED,
        LOST
    } state_t;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_EXP_PERIOD = 6;
    localparam int DEF_TOL        = 1;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_TIMEOUT    = 16;

    function automatic logic period_ok(input int p, input int exp_p, input int tol);
        return ((p + tol) >= exp_p) && (p <= (exp_p + tol));
    endfunction

endpackage

// File: rtl/clk_mon_sync_edge.sv
// Two-flop synchronizer plus a rising-edge detector for any asynchronous input.
module sync_edge (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_mon.sv
// Monitors the divided clock in the clk_in domain: edge ticks, period
// measurement, lock tracking, stopped-clock detection and error counting.
module clk_mon
    import clk_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             mon_clk,
    input  logic             en,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             lost,
    output logic [7:0]       err_cnt
);

    localparam int               GC_W     = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  LOCK_VAL = GC_W'(LOCK_CNT);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [GC_W-1:0]  good_cnt;
    logic [7:0]       err_base;
    logic             rise;
    logic             good;
    logic             measuring;
    logic             meas_rise;
    logic             bad_evt;
    logic             lock_evt;
    logic             timeout_evt;
    logic             start_evt;

    sync_edge u_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .async_in (mon_clk),
        .rise     (rise)
    );

    assign good = period_ok(32'(cnt), EXP_PERIOD, TOL);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Dropping en overrides every other transition.
    always_comb begin
        next_state = state;
        if (!en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      next_state = ACQ;
                ACQ, LOST: if (start_evt) next_state = MEAS;
                MEAS: begin
                    if (lock_evt)         next_state = LOCKED;
                    else if (timeout_evt) next_state = LOST;
                end
                LOCKED: begin
                    if (bad_evt)          next_state = MEAS;
                    else if (timeout_evt) next_state = LOST;
                end
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        measuring   = en && ((state == MEAS) || (state == LOCKED));
        meas_rise   = measuring && rise;
        bad_evt     = meas_rise && !good;
        lock_evt    = meas_rise && good && (state == MEAS) &&
                      ((good_cnt + GC_W'(1)) == LOCK_VAL);
        timeout_evt = measuring && !rise && (cnt >= TO_VAL);
        start_evt   = en && rise && ((state == ACQ) || (state == LOST));
        locked      = (state == LOCKED);
        err_base    = clr ? 8'd0 : err_cnt;
    end

    // clr is applied first so a simultaneous error still leaves a count of one.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick       <= 1'b0;
            period_vld <= 1'b0;
            period     <= '0;
            cnt        <= '0;
            good_cnt   <= '0;
            lost       <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            tick       <= rise & en;
            period_vld <= meas_rise;
            if (meas_rise) begin
                period <= cnt;
            end

            if (!en || (state == IDLE)) begin
                cnt <= '0;
            end else if (rise) begin
                cnt <= CNT_W'(1);
            end else if ((state != ACQ) && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (!en || (state == IDLE) || start_evt || bad_evt || timeout_evt) begin
                good_cnt <= '0;
            end else if (meas_rise && good && (state == MEAS)) begin
                good_cnt <= good_cnt + GC_W'(1);
            end

            if (timeout_evt) begin
                lost <= 1'b1;
            end else if (clr) begin
                lost <= 1'b0;
            end

            if (bad_evt && (err_base != 8'hFF)) begin
                err_cnt <= err_base + 8'd1;
            end else begin
                err_cnt <= err_base;
            end
        end
    end

endmodule

// File: tb/tb_clk_mon.sv
// Directed bench for clk_mon: stimulus queues expected periods, a monitor
// pops them on every period_vld; status flags are checked at fixed points.
module tb_clk_mon;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       mon_clk;
    logic       en;
    logic       clr;
    logic       tick;
    logic [7:0] period;
    logic       period_vld;
    logic       locked;
    logic       lost;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    clk_mon #(
        .CNT_W      (8),
        .EXP_PERIOD (6),
        .TOL        (1),
        .LOCK_CNT   (4),
        .TIMEOUT    (16)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .mon_clk    (mon_clk),
        .en         (en),
        .clr        (clr),
        .tick       (tick),
        .period     (period),
        .period_vld (period_vld),
        .locked     (locked),
        .lost       (lost),
        .err_cnt    (err_cnt)
    );

    always #10 clk_in = ~clk_in;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One mon_clk period of p clk_in cycles, starting with the rising edge.
    // Must be called at a falling clk_in edge.
    task automatic apply_stimulus(input int p, input bit vld, input int exp_p);
        if (vld) exp_q.push_back(exp_p);
        mon_clk = 1'b1;
        repeat (p / 2) @(negedge clk_in);
        mon_clk = 1'b0;
        repeat (p - p / 2) @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin
        if (rst_n && period_vld) begin
            check_output("vld_with_tick", 32'(tick), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_vld: got period_vld=1 with period %0d, expected no update", period);
            end else begin
                check_output("period", 32'(period), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        mon_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        check_output("rst_tick", 32'(tick), 0);
        check_output("rst_period", 32'(period), 0);
        check_output("rst_vld", 32'(period_vld), 0);
        check_output("rst_locked", 32'(locked), 0);
        check_output("rst_lost", 32'(lost), 0);
        check_output("rst_err", 32'(err_cnt), 0);

        rst_n = 1'b1;
        @(negedge clk_in);
        en = 1'b1;
        repeat (2) @(negedge clk_in);

        // First rise: tick latency, no period update.
        fork
            apply_stimulus(6, 1'b0, 0);
            begin
                repeat (2) @(posedge clk_in);
                #1 check_output("tick_early", 32'(tick), 0);
                @(posedge clk_in);
                #1 check_output("tick_latency", 32'(tick), 1);
                check_output("first_rise_no_vld", 32'(period_vld), 0);
            end
        join
        repeat (3) apply_stimulus(6, 1'b1, 6);
        check_output("unlocked_after_4", 32'(locked), 0);
        apply_stimulus(6, 1'b1, 6);
        check_output("locked_after_5", 32'(locked), 1);
        check_output("err_after_lock", 32'(err_cnt), 0);

        // Stopped clock: lost exactly 16 cycles after the last rise.
        repeat (12) @(posedge clk_in);
        #1 check_output("lost_before_to", 32'(lost), 0);
        check_output("locked_before_to", 32'(locked), 1);
        @(posedge clk_in);
        #1 check_output("lost_at_to", 32'(lost), 1);
        check_output("locked_at_to", 32'(locked), 0);
        @(negedge clk_in);
        apply_stimulus(6, 1'b0, 0);
        repeat (3) apply_stimulus(6, 1'b1, 6);
        check_output("relock_pending", 32'(locked), 0);
        check_output("lost_sticky", 32'(lost), 1);
        apply_stimulus(6, 1'b1, 6);
        check_output("relocked", 32'(locked), 1);
        check_output("lost_still_set", 32'(lost), 1);
        fork
            apply_stimulus(6, 1'b1, 6);
            begin
                clr = 1'b1;
                @(negedge clk_in);
                clr = 1'b0;
            end
        join
        check_output("lost_cleared", 32'(lost), 0);

        // Tolerance edges 7 and 5 keep lock; 8 breaks it.
        apply_stimulus(7, 1'b1, 6);
        apply_stimulus(5, 1'b1, 7);
        apply_stimulus(8, 1'b1, 5);
        check_output("tol_locked", 32'(locked), 1);
        check_output("tol_err", 32'(err_cnt), 0);
        apply_stimulus(6, 1'b1, 8);
        check_output("p8_unlocked", 32'(locked), 0);
        check_output("p8_err", 32'(err_cnt), 1);
        repeat (4) apply_stimulus(6, 1'b1, 6);
        check_output("p8_relock", 32'(locked), 1);

        // Stretched period of 9.
        apply_stimulus(9, 1'b1, 6);
        apply_stimulus(6, 1'b1, 9);
        check_output("p9_unlocked", 32'(locked), 0);
        check_output("p9_err", 32'(err_cnt), 2);
        repeat (3) apply_stimulus(6, 1'b1, 6);
        check_output("p9_relock_pending", 32'(locked), 0);
        apply_stimulus(6, 1'b1, 6);
        check_output("p9_relock", 32'(locked), 1);

        // clr on the same edge as a bad period.
        apply_stimulus(9, 1'b1, 6);
        fork
            apply_stimulus(6, 1'b1, 9);
            begin
                repeat (2) @(negedge clk_in);
                clr = 1'b1;
                @(negedge clk_in);
                clr = 1'b0;
            end
        join
        check_output("clr_vs_bad_err", 32'(err_cnt), 1);
        check_output("clr_vs_bad_locked", 32'(locked), 0);

        // Saturation: one good then 299 bad periods of 3.
        apply_stimulus(3, 1'b1, 6);
        repeat (299) apply_stimulus(3, 1'b1, 3);
        check_output("err_saturated", 32'(err_cnt), 255);
        check_output("period_short", 32'(period), 3);
        apply_stimulus(6, 1'b1, 3);
        repeat (4) apply_stimulus(6, 1'b1, 6);
        check_output("sat_relock", 32'(locked), 1);
        check_output("err_held_255", 32'(err_cnt), 255);

        // Asynchronous reset between clock edges.
        #3 rst_n = 1'b0;
        #1;
        check_output("arst_locked", 32'(locked), 0);
        check_output("arst_period", 32'(period), 0);
        check_output("arst_err", 32'(err_cnt), 0);
        check_output("arst_tick", 32'(tick), 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);

        // Relock with one error, then drop en while locked.
        apply_stimulus(6, 1'b0, 0);
        apply_stimulus(9, 1'b1, 6);
        apply_stimulus(6, 1'b1, 9);
        repeat (4) apply_stimulus(6, 1'b1, 6);
        check_output("pre_en_locked", 32'(locked), 1);
        check_output("pre_en_err", 32'(err_cnt), 1);
        fork
            apply_stimulus(6, 1'b0, 0);
            begin
                en = 1'b0;
                @(posedge clk_in);
                #1 check_output("en_off_locked", 32'(locked), 0);
                repeat (2) @(posedge clk_in);
                #1 check_output("en_off_tick", 32'(tick), 0);
            end
        join
        check_output("en_off_err_kept", 32'(err_cnt), 1);
        check_output("en_off_lost", 32'(lost), 0);

        repeat (10) @(negedge clk_in);
        check_output("queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
